median_window_3x3: RTL and testbench

- Streaming 3x3 neighbourhood generator that sits directly upstream of the 9-input, 8-bit median sorter (`NUM_VALS=9`).
- Accepts one pixel per cycle in raster order and keeps two line buffers plus a 3x3 window register.
- Emits a packed 9-pixel window, one cycle after the accepted pixel that completes it, in exactly the concatenation order the sorter's `in` bus expects.
- Only fully populated windows are emitted: no padding, no border replication.

---
 rtl/median_window_3x3.sv | 113 +++++++++++
 tb/tb_median_window_3x3.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/median_window_3x3.sv
// 3x3 raster neighbourhood generator feeding the 9-input median sorter; two line buffers plus window regs.
// Latency 1 cycle from the completing pixel; no backpressure, the sorter takes a window every cycle.
// Optional MEDIAN_WIN_COUNT_EN adds a per-frame emitted-window counter (win_count).
module median_window_3x3 #(
    parameter int SIZE       = 8,
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [SIZE-1:0]   in_pixel,
    output logic              win_valid,
    output logic [9*SIZE-1:0] win,
    output logic              win_eof
`ifdef MEDIAN_WIN_COUNT_EN
    ,
    output logic [15:0]       win_count
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] pcol;
    logic [RW-1:0] prow;
    logic          last_col;
    logic          last_row;
    logic          win_hit;
    logic          win_end;

    logic [SIZE-1:0] lb1 [IMG_WIDTH];
    logic [SIZE-1:0] lb2 [IMG_WIDTH];
    logic [SIZE-1:0] w   [9];

    // in_sof forces the accepted pixel to (0,0) whatever the counters say.
    assign pcol     = in_sof ? '0 : col;
    assign prow     = in_sof ? '0 : row;
    assign last_col = (pcol == COL_LAST);
    assign last_row = (prow == ROW_LAST);
    assign win_hit  = in_valid && (prow >= RW'(2)) && (pcol >= CW'(2));
    assign win_end  = win_hit && last_row && last_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : prow + RW'(1);
            end else begin
                col <= pcol + CW'(1);
                row <= prow;
            end
        end
    end

    // Line buffers carry no reset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb2[pcol] <= lb1[pcol];
            lb1[pcol] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                w[i] <= '0;
            end
            win_valid <= 1'b0;
            win_eof   <= 1'b0;
        end else begin
            win_valid <= win_hit;
            win_eof   <= win_end;
            if (in_valid) begin
                w[0] <= w[1];
                w[1] <= w[2];
                w[2] <= lb2[pcol];
                w[3] <= w[4];
                w[4] <= w[5];
                w[5] <= lb1[pcol];
                w[6] <= w[7];
                w[7] <= w[8];
                w[8] <= in_pixel;
            end
        end
    end

    assign win = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8]};

`ifdef MEDIAN_WIN_COUNT_EN
    // Updated on the same edge as win_valid so the count already includes the window on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_count <= '0;
        end else if (in_valid && in_sof) begin
            win_count <= '0;
        end else if (win_eof) begin
            win_count <= '0;
        end else if (win_hit && (win_count != 16'hFFFF)) begin
            win_count <= win_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_median_window_3x3.sv
// Scoreboard bench for median_window_3x3 on a 4x4 image with pixel value 4*row+col (+base).
module tb_median_window_3x3;

    localparam int W = 4;
    localparam int H = 4;
    localparam int S = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [S-1:0]  in_pixel = '0;
    logic          win_valid;
    logic [9*S-1:0] win;
    logic          win_eof;
`ifdef MEDIAN_WIN_COUNT_EN
    logic [15:0]   win_count;
`endif

    median_window_3x3 #(.SIZE(S), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .win_valid (win_valid),
        .win       (win),
        .win_eof   (win_eof)
`ifdef MEDIAN_WIN_COUNT_EN
        ,
        .win_count (win_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] w;
        logic        eof;
        logic [15:0] cnt;
        logic [31:0] due;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          rcv = 0;
    int          exp_total = 0;
    logic        hold_chk = 1'b0;
    logic        fin = 1'b0;
    logic        fin_done = 1'b0;
    logic        prev_eof = 1'b0;
    logic [71:0] w0_const = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] acc;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = (acc << 8) | 72'(8'(base + 4 * (r - 2 + i) + (c - 2 + j)));
            end
        end
        return acc;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_win_valid", 72'(win_valid), 72'd0);
            chk("rst_win", win, 72'd0);
            chk("rst_win_eof", 72'(win_eof), 72'd0);
            prev_eof = 1'b0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                mon_e = q.pop_front();
                chk("win_valid", 72'(win_valid), 72'd1);
                chk("win", win, mon_e.w);
                chk("win_eof", 72'(win_eof), 72'(mon_e.eof));
`ifdef MEDIAN_WIN_COUNT_EN
                chk("win_count", 72'(win_count), 72'(mon_e.cnt));
`endif
                rcv++;
            end else begin
                chk("win_valid_idle", 72'(win_valid), 72'd0);
                chk("win_eof_idle", 72'(win_eof), 72'd0);
                if (hold_chk) chk("win_hold", win, w0_const);
`ifdef MEDIAN_WIN_COUNT_EN
                if (prev_eof) chk("win_count_clear", 72'(win_count), 72'd0);
`endif
            end
            prev_eof = win_valid & win_eof;
        end
        if (fin && !fin_done) begin
            chk("window_total", 72'(rcv), 72'(exp_total));
            chk("queue_empty", 72'(q.size()), 72'd0);
            fin_done = 1'b1;
        end
    end

    task automatic send(input logic [7:0] v, input logic s, input logic do_push,
                        input logic [71:0] ew, input logic eeof, input logic [15:0] ecnt);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = s;
        in_pixel = v;
        hold_chk = 1'b0;
        if (do_push) begin
            e.w   = ew;
            e.eof = eeof;
            e.cnt = ecnt;
            e.due = cyc + 1;
            q.push_back(e);
            exp_total++;
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic hold);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        hold_chk = hold;
        @(posedge clk);
    endtask

    // Sends pixels 0..last_idx of a frame; windows completed by pixels up to push_lim are expected.
    task automatic run_frame(input int base, input logic sof, input int gap_after,
                             input int last_idx, input int push_lim);
        int k;
        int r;
        int c;
        k = 0;
        for (int p = 0; p <= last_idx; p++) begin
            r = p / W;
            c = p % W;
            if (r >= 2 && c >= 2 && p <= push_lim) begin
                k++;
                send(8'(base + p), sof && (p == 0), 1'b1, exp_win(base, r, c),
                     (r == H - 1) && (c == W - 1), 16'(k));
            end else begin
                send(8'(base + p), sof && (p == 0), 1'b0, '0, 1'b0, '0);
            end
            if (p == gap_after) begin
                for (int g = 0; g < 3; g++) idle(1'b1);
            end
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) idle(1'b0);

        // Continuous frame
        run_frame(0, 1'b1, -1, 15, 15);
        repeat (3) idle(1'b0);

        // Three-cycle gap after pixel 10
        run_frame(0, 1'b1, 10, 15, 15);
        repeat (3) idle(1'b0);

        // Back-to-back frames, second without in_sof
        run_frame(0, 1'b1, -1, 15, 15);
        run_frame(100, 1'b0, -1, 15, 15);
        repeat (3) idle(1'b0);

        // Stale partial frame, then restart with in_sof at pixel 6
        for (int p = 0; p < 6; p++) send(8'(200 + p), p == 0, 1'b0, '0, 1'b0, '0);
        run_frame(0, 1'b1, -1, 15, 15);
        repeat (3) idle(1'b0);

        // Asynchronous reset after pixel 11 is accepted
        run_frame(0, 1'b1, -1, 11, 10);
        #2 rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) idle(1'b0);
        run_frame(0, 1'b1, -1, 15, 15);
        repeat (3) idle(1'b0);

        fin = 1'b1;
        repeat (3) @(negedge clk);
        if (!fin_done) begin
            errors++;
            checks++;
            $display("FAIL final_check: got not_done expected done");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
